// File: rtl/char_box_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : char_box_pkg
//  Purpose  : Shared types and constants for the character box overlay:
//             box count, coordinate width, box column pair, FSM states and
//             a valid-flag popcount helper.
//  Revision : 1.0  initial release
// ============================================================================
package char_box_pkg;

    localparam int NUM_BOX = 8;
    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    // Left / right column of one character box.
    typedef struct packed {
        coord_t l;
        coord_t r;
    } box_t;

    typedef enum logic [0:0] {
        ST_WAIT_FIRST = 1'b0,
        ST_ACTIVE     = 1'b1
    } state_e;

    function automatic logic [3:0] popcount(input logic [NUM_BOX-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < NUM_BOX; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_box_overlay_if.sv
`default_nettype none
// ============================================================================
//  Module   : char_box_overlay_if
//  Purpose  : Video-in / box-list / video-out bundle of char_box_overlay.
//             slave  : the overlay (consumes i_*, produces o_*)
//             master : the video source / sink driving the overlay
//  Revision : 1.0  initial release
// ============================================================================
interface char_box_overlay_if #(
    parameter int IMG_WIDTH_DATA = 24
);
    import char_box_pkg::*;

    logic [IMG_WIDTH_DATA-1:0]    i_rgb;
    logic                         i_hs;
    logic                         i_vs;
    logic                         i_de;
    logic [COORD_W-1:0]           i_hcount;
    logic [COORD_W-1:0]           i_vcount;
    logic [2:0]                   i_frame_cnt;
    logic [NUM_BOX*COORD_W-1:0]   i_box_l;
    logic [NUM_BOX*COORD_W-1:0]   i_box_r;
    logic [COORD_W-1:0]           i_row_t;
    logic [COORD_W-1:0]           i_row_b;

    logic [IMG_WIDTH_DATA-1:0]    o_rgb;
    logic                         o_hs;
    logic                         o_vs;
    logic                         o_de;
    logic [3:0]                   o_box_cnt;

    modport slave (
        input  i_rgb, i_hs, i_vs, i_de, i_hcount, i_vcount, i_frame_cnt,
               i_box_l, i_box_r, i_row_t, i_row_b,
        output o_rgb, o_hs, o_vs, o_de, o_box_cnt
    );

    modport master (
        output i_rgb, i_hs, i_vs, i_de, i_hcount, i_vcount, i_frame_cnt,
               i_box_l, i_box_r, i_row_t, i_row_b,
        input  o_rgb, o_hs, o_vs, o_de, o_box_cnt
    );

endinterface
`default_nettype wire

// File: rtl/char_box_hit.sv
`default_nettype none
// ============================================================================
//  Module   : char_box_hit
//  Purpose  : Combinational border / interior test of one box against the
//             current pixel coordinate. Validity gating is left to the parent.
//  Ports    : i_h, i_v          pixel column / row
//             i_box             box left / right column
//             i_row_t, i_row_b  common top / bottom row
//             o_border          pixel lies on the BOX_THICK-wide border
//             o_inner           pixel lies inside the box, off the border
//  Revision : 1.0  initial release
// ============================================================================
module char_box_hit
    import char_box_pkg::*;
#(
    parameter int BOX_THICK = 2
) (
    input  coord_t i_h,
    input  coord_t i_v,
    input  box_t   i_box,
    input  coord_t i_row_t,
    input  coord_t i_row_b,
    output logic   o_border,
    output logic   o_inner
);

    localparam coord_t c_THICK = coord_t'(BOX_THICK);

    logic w_inside;
    logic w_edge;

    always_comb begin
        w_inside = (i_v >= i_row_t) && (i_v <= i_row_b) &&
                   (i_h >= i_box.l) && (i_h <= i_box.r);
        // The differences may wrap when the pixel is outside the box, but
        // they are only meaningful (and only used) when w_inside is set.
        // A box narrower than 2*BOX_THICK has every column within BOX_THICK
        // of one side, so its whole interior becomes border automatically.
        w_edge   = ((i_h - i_box.l) < c_THICK) ||
                   ((i_box.r - i_h) < c_THICK) ||
                   ((i_v - i_row_t) < c_THICK) ||
                   ((i_row_b - i_v) < c_THICK);
        o_border = w_inside && w_edge;
        o_inner  = w_inside && !w_edge;
    end

endmodule
`default_nettype wire

// File: rtl/char_box_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : char_box_overlay
//  Purpose  : Draws up to eight character boxes (common top/bottom row) over
//             a video stream. Box coordinates are captured into shadows at
//             the vs falling edge of the frame in which upstream results are
//             stable, then applied to the following pixels with a fixed
//             two-cycle latency.
//  Ports    : pixelclk  only clock
//             reset     synchronous, active high
//             bus       char_box_overlay_if.slave (video in, box list,
//                       video out, o_box_cnt)
//  Macro    : CHAR_BOX_FILL_EN - tint interior pixels with
//             (pix>>1)+(BOX_COLOR>>1) per 8-bit channel; otherwise the
//             interior passes through unchanged. Latency is identical.
//  Revision : 1.0  initial release
// ============================================================================
module char_box_overlay
    import char_box_pkg::*;
#(
    parameter int                        IMG_WIDTH_DATA = 24,
    parameter logic [IMG_WIDTH_DATA-1:0] BOX_COLOR      = IMG_WIDTH_DATA'(24'hFF0000),
    parameter int                        BOX_THICK      = 2,
    parameter int                        CAPTURE_FRAME  = 3
) (
    input  logic                    pixelclk,
    input  logic                    reset,
    char_box_overlay_if.slave       bus
);

    localparam logic [2:0] c_CAP_FRAME = 3'(CAPTURE_FRAME);

    // ---------------- shadow / control state ----------------
    box_t [NUM_BOX-1:0]        r_box_q,     w_box_d;
    coord_t                    r_row_t_q,   w_row_t_d;
    coord_t                    r_row_b_q,   w_row_b_d;
    logic                      r_cap_q,     w_cap_d;
    logic [3:0]                r_box_cnt_q, w_box_cnt_d;
    state_e                    r_state_q,   w_state_d;

    // ---------------- stage 1 ----------------
    logic [IMG_WIDTH_DATA-1:0] r_pix_q,     w_pix_d;
    logic                      r_hit_q,     w_hit_d;
    logic                      r_inner_q,   w_inner_d;
    logic                      r_hs1_q,     w_hs1_d;
    logic                      r_vs1_q,     w_vs1_d;
    logic                      r_de1_q,     w_de1_d;

    // ---------------- stage 2 ----------------
    logic [IMG_WIDTH_DATA-1:0] r_rgb_q,     w_rgb_d;
    logic                      r_hs2_q,     w_hs2_d;
    logic                      r_vs2_q,     w_vs2_d;
    logic                      r_de2_q,     w_de2_d;

    logic                      w_capture;
    logic                      w_rows_ok;
    logic [NUM_BOX-1:0]        w_valid;
    logic [NUM_BOX-1:0]        w_border;
    logic [NUM_BOX-1:0]        w_inner;
    logic [3:0]                w_valid_cnt;
    logic [IMG_WIDTH_DATA-1:0] w_fill;

    assign w_rows_ok   = r_row_b_q > r_row_t_q;
    assign w_valid_cnt = popcount(w_valid);

    generate
        for (genvar k = 0; k < NUM_BOX; k++) begin : g_box
            assign w_valid[k] = w_rows_ok && (r_box_q[k].r > r_box_q[k].l);

            char_box_hit #(
                .BOX_THICK (BOX_THICK)
            ) u_hit (
                .i_h      (bus.i_hcount),
                .i_v      (bus.i_vcount),
                .i_box    (r_box_q[k]),
                .i_row_t  (r_row_t_q),
                .i_row_b  (r_row_b_q),
                .o_border (w_border[k]),
                .o_inner  (w_inner[k])
            );
        end
    endgenerate

`ifdef CHAR_BOX_FILL_EN
    // Halving both operands keeps each channel sum within 8 bits.
    generate
        for (genvar ch = 0; ch < IMG_WIDTH_DATA / 8; ch++) begin : g_fill
            assign w_fill[ch*8 +: 8] = {1'b0, r_pix_q[ch*8+1 +: 7]} +
                                       {1'b0, BOX_COLOR[ch*8+1 +: 7]};
        end
    endgenerate
`else
    assign w_fill = r_pix_q;
`endif

    // ---------------- capture and datapath next-state ----------------
    always_comb begin
        // r_vs1_q doubles as the registered vs used for edge detection.
        w_capture   = r_vs1_q && !bus.i_vs && (bus.i_frame_cnt == c_CAP_FRAME);

        w_box_d     = r_box_q;
        w_row_t_d   = r_row_t_q;
        w_row_b_d   = r_row_b_q;
        if (w_capture) begin
            for (int k = 0; k < NUM_BOX; k++) begin
                w_box_d[k].l = bus.i_box_l[k*COORD_W +: COORD_W];
                w_box_d[k].r = bus.i_box_r[k*COORD_W +: COORD_W];
            end
            w_row_t_d = bus.i_row_t;
            w_row_b_d = bus.i_row_b;
        end

        // The count follows the shadows one cycle after they change.
        w_cap_d     = w_capture;
        w_box_cnt_d = r_cap_q ? w_valid_cnt : r_box_cnt_q;

        // Stage 1: only valid boxes in ACTIVE may hit.
        w_pix_d     = bus.i_rgb;
        w_hit_d     = (r_state_q == ST_ACTIVE) && |(w_border & w_valid);
        w_inner_d   = (r_state_q == ST_ACTIVE) && |(w_inner  & w_valid);
        w_hs1_d     = bus.i_hs;
        w_vs1_d     = bus.i_vs;
        w_de1_d     = bus.i_de;

        // Stage 2: output mux; blanking forces black. Border wins over the
        // interior of an overlapping box.
        w_rgb_d     = '0;
        if (r_de1_q) begin
            if (r_hit_q) begin
                w_rgb_d = BOX_COLOR;
            end else if (r_inner_q) begin
                w_rgb_d = w_fill;
            end else begin
                w_rgb_d = r_pix_q;
            end
        end
        w_hs2_d     = r_hs1_q;
        w_vs2_d     = r_vs1_q;
        w_de2_d     = r_de1_q;
    end

    // ---------------- FSM next-state ----------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_WAIT_FIRST: if (r_cap_q && (w_valid_cnt != 4'd0)) w_state_d = ST_ACTIVE;
            ST_ACTIVE:     if (r_cap_q && (w_valid_cnt == 4'd0)) w_state_d = ST_WAIT_FIRST;
            default:       w_state_d = ST_WAIT_FIRST;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            r_box_q     <= '0;
            r_row_t_q   <= '0;
            r_row_b_q   <= '0;
            r_cap_q     <= 1'b0;
            r_box_cnt_q <= '0;
            r_state_q   <= ST_WAIT_FIRST;
            r_pix_q     <= '0;
            r_hit_q     <= 1'b0;
            r_inner_q   <= 1'b0;
            r_hs1_q     <= 1'b0;
            r_vs1_q     <= 1'b0;
            r_de1_q     <= 1'b0;
            r_rgb_q     <= '0;
            r_hs2_q     <= 1'b0;
            r_vs2_q     <= 1'b0;
            r_de2_q     <= 1'b0;
        end else begin
            r_box_q     <= w_box_d;
            r_row_t_q   <= w_row_t_d;
            r_row_b_q   <= w_row_b_d;
            r_cap_q     <= w_cap_d;
            r_box_cnt_q <= w_box_cnt_d;
            r_state_q   <= w_state_d;
            r_pix_q     <= w_pix_d;
            r_hit_q     <= w_hit_d;
            r_inner_q   <= w_inner_d;
            r_hs1_q     <= w_hs1_d;
            r_vs1_q     <= w_vs1_d;
            r_de1_q     <= w_de1_d;
            r_rgb_q     <= w_rgb_d;
            r_hs2_q     <= w_hs2_d;
            r_vs2_q     <= w_vs2_d;
            r_de2_q     <= w_de2_d;
        end
    end

    assign bus.o_rgb     = r_rgb_q;
    assign bus.o_hs      = r_hs2_q;
    assign bus.o_vs      = r_vs2_q;
    assign bus.o_de      = r_de2_q;
    assign bus.o_box_cnt = r_box_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_char_box_overlay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_char_box_overlay
//  Purpose  : Scoreboard bench for char_box_overlay. Frames of a small raster
//             are generated with random pixels and box lists; a reference
//             model written from the box-drawing rules predicts each output
//             cycle, and a monitor compares the DUT against the queued
//             predictions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_char_box_overlay;
    import char_box_pkg::*;

    localparam int          W     = 24;
    localparam logic [23:0] C_BOX = 24'hFF0000;
    localparam int          THICK = 2;
    localparam int          CAP   = 3;
    localparam int          HACT  = 32;
    localparam int          VACT  = 20;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic [3:0]  cnt;
    } sb_t;

    logic pixelclk = 1'b0;
    logic reset    = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    sb_t  exp_q[$];

    // reference model state
    int   m_l[NUM_BOX];
    int   m_r[NUM_BOX];
    int   m_t, m_b, m_cnt;
    bit   m_active;
    bit   m_vs_prev;

    char_box_overlay_if #(.IMG_WIDTH_DATA(W)) bus ();

    char_box_overlay #(
        .IMG_WIDTH_DATA (W),
        .BOX_COLOR      (C_BOX),
        .BOX_THICK      (THICK),
        .CAPTURE_FRAME  (CAP)
    ) dut (
        .pixelclk (pixelclk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 pixelclk = ~pixelclk;
    always @(posedge pixelclk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [23:0] model_rgb(int h, int v, logic [23:0] pix, bit de);
        bit border;
        bit inner;
        border = 1'b0;
        inner  = 1'b0;
        if (!de) return 24'h0;
        if (m_active) begin
            for (int k = 0; k < NUM_BOX; k++) begin
                if (m_r[k] > m_l[k] && m_b > m_t &&
                    v >= m_t && v <= m_b && h >= m_l[k] && h <= m_r[k]) begin
                    if (h - m_l[k] < THICK || m_r[k] - h < THICK ||
                        v - m_t < THICK || m_b - v < THICK)
                        border = 1'b1;
                    else
                        inner = 1'b1;
                end
            end
        end
        if (border) return C_BOX;
`ifdef CHAR_BOX_FILL_EN
        if (inner) begin
            int pv, cv, res;
            pv  = int'(pix);
            cv  = int'(C_BOX);
            res = 0;
            for (int c = 0; c < 3; c++)
                res += ((((pv >> (8*c)) & 255) / 2) + (((cv >> (8*c)) & 255) / 2)) << (8*c);
            return 24'(res);
        end
`else
        if (inner) return pix;
`endif
        return pix;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NUM_BOX; k++) begin
            m_l[k] = 0;
            m_r[k] = 0;
        end
        m_t = 0; m_b = 0; m_cnt = 0;
        m_active  = 1'b0;
        m_vs_prev = 1'b0;
    endfunction

    // One pixel clock of stimulus; pushes the predicted output two cycles on.
    task automatic step(bit hs, bit vs, bit de, int h, int v, bit rst_now, bit fixed);
        sb_t         e;
        logic [23:0] pix;
        pix = fixed ? 24'h202020 : 24'($urandom);
        @(posedge pixelclk);
        #1;
        bus.i_hs     = hs;
        bus.i_vs     = vs;
        bus.i_de     = de;
        bus.i_hcount = 12'(h);
        bus.i_vcount = 12'(v);
        bus.i_rgb    = pix;
        reset        = rst_now;
        if (rst_now) begin
            // reset wipes whatever was in flight; outputs read 0 for two cycles
            while (exp_q.size() > 0 && exp_q[$].due >= cyc + 1) void'(exp_q.pop_back());
            model_reset();
            for (int d = 1; d <= 2; d++) begin
                e = '{due: cyc + d, rgb: 24'h0, hs: 1'b0, vs: 1'b0, de: 1'b0, cnt: 4'd0};
                exp_q.push_back(e);
            end
        end else begin
            if (m_vs_prev && !vs && int'(bus.i_frame_cnt) == CAP) begin
                m_cnt = 0;
                for (int k = 0; k < NUM_BOX; k++) begin
                    m_l[k] = int'(bus.i_box_l[k*12 +: 12]);
                    m_r[k] = int'(bus.i_box_r[k*12 +: 12]);
                end
                m_t = int'(bus.i_row_t);
                m_b = int'(bus.i_row_b);
                for (int k = 0; k < NUM_BOX; k++)
                    if (m_r[k] > m_l[k] && m_b > m_t) m_cnt++;
                m_active = (m_cnt != 0);
            end
            m_vs_prev = vs;
            e = '{due: cyc + 2, rgb: model_rgb(h, v, pix, de), hs: hs, vs: vs, de: de,
                  cnt: 4'(m_cnt)};
            exp_q.push_back(e);
        end
    endtask

    // One frame: vs pulse (falling edge carries fc), blank gap, active lines.
    task automatic frame(int fc, logic [95:0] bl, logic [95:0] br, logic [11:0] rt,
                         logic [11:0] rb, int rst_v, int rst_h, bit rst_cap, bit fixed);
        bus.i_frame_cnt = 3'(fc);
        bus.i_box_l     = bl;
        bus.i_box_r     = br;
        bus.i_row_t     = rt;
        bus.i_row_b     = rb;
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, rst_cap, 0);
        repeat (6) step(0, 0, 0, 0, 0, 0, 0);
        for (int v = 0; v < VACT; v++) begin
            for (int h = 0; h < HACT; h++)
                step(0, 0, 1, h, v, (v == rst_v && h == rst_h), fixed);
            repeat (2) step(1, 0, 0, 0, 0, 0, 0);
        end
    endtask

    function automatic void rand_boxes(output logic [95:0] bl, output logic [95:0] br,
                                       output logic [11:0] rt, output logic [11:0] rb);
        int l, r;
        bl = '0;
        br = '0;
        for (int k = 0; k < NUM_BOX; k++) begin
            l = int'($urandom_range(0, 40));
            case ($urandom_range(0, 3))
                0:       r = l;                                   // invalid
                1:       r = l + int'($urandom_range(1, 3));      // narrow
                2:       r = l + int'($urandom_range(4, 20));
                default: begin l = int'($urandom_range(4000, 4090)); r = l + 3; end
            endcase
            bl[k*12 +: 12] = 12'(l);
            br[k*12 +: 12] = 12'(r);
        end
        rt = 12'($urandom_range(0, 10));
        rb = rt + 12'($urandom_range(1, 10));
    endfunction

    // ---------------- monitor ----------------
    sb_t mon_e;
    always @(negedge pixelclk) begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL stale_entry due=%0d now=%0d", mon_e.due, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.o_rgb !== mon_e.rgb || bus.o_hs !== mon_e.hs ||
                bus.o_vs !== mon_e.vs || bus.o_de !== mon_e.de) begin
                failures++;
                $display("FAIL video cyc=%0d got rgb=%h hs=%b vs=%b de=%b want rgb=%h hs=%b vs=%b de=%b",
                         cyc, bus.o_rgb, bus.o_hs, bus.o_vs, bus.o_de,
                         mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.de);
            end
            checks++;
            if (bus.o_box_cnt !== mon_e.cnt) begin
                failures++;
                $display("FAIL box_cnt cyc=%0d got %0d want %0d", cyc, bus.o_box_cnt, mon_e.cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [95:0] a_l, a_r, b_l, b_r, z, x_l, x_r;
    logic [11:0] x_t, x_b;

    initial begin
        bus.i_rgb = '0; bus.i_hs = 0; bus.i_vs = 0; bus.i_de = 0;
        bus.i_hcount = '0; bus.i_vcount = '0; bus.i_frame_cnt = '0;
        bus.i_box_l = '0; bus.i_box_r = '0; bus.i_row_t = '0; bus.i_row_b = '0;
        model_reset();

        z   = '0;
        a_l = '0; a_r = '0;
        a_l[11:0] = 12'd10; a_r[11:0] = 12'd20;                 // box0 only
        b_l = a_l;  b_r = a_r;
        b_l[23:12] = 12'd20; b_r[23:12] = 12'd22;               // + narrow box1

        repeat (3) step(0, 0, 0, 0, 0, 1, 0);

        frame(3, a_l, a_r, 12'd5, 12'd15, -1, -1, 0, 0);        // first capture
        rand_boxes(x_l, x_r, x_t, x_b);
        frame(2, x_l, x_r, x_t, x_b, -1, -1, 0, 0);             // ignored phase
        frame(3, b_l, b_r, 12'd5, 12'd15, -1, -1, 0, 0);        // overlap
        frame(3, a_l, a_r, 12'd5, 12'd15, -1, -1, 0, 1);        // flat 0x202020
        rand_boxes(x_l, x_r, x_t, x_b);
        frame(3, x_l, x_r, x_t, x_b, -1, -1, 0, 0);
        rand_boxes(x_l, x_r, x_t, x_b);
        frame(4, x_l, x_r, x_t, x_b, -1, -1, 0, 0);             // ignored phase
        frame(3, z, z, 12'd0, 12'd0, -1, -1, 0, 0);             // back to WAIT_FIRST
        frame(3, a_l, a_r, 12'd5, 12'd15, -1, -1, 0, 0);
        frame(3, b_l, b_r, 12'd5, 12'd15, 8, 12, 0, 0);         // reset mid-line
        frame(3, a_l, a_r, 12'd5, 12'd15, -1, -1, 1, 0);        // reset on capture
        rand_boxes(x_l, x_r, x_t, x_b);
        frame(3, x_l, x_r, x_t, x_b, -1, -1, 0, 0);
        rand_boxes(x_l, x_r, x_t, x_b);
        frame(3, x_l, x_r, x_t, x_b, -1, -1, 0, 0);

        repeat (5) @(negedge pixelclk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain leftover=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/char_box_overlay.md
CHAR_BOX_OVERLAY -- requirements
Module: char_box_overlay

Interface
REQ-001 SHALL have parameter IMG_WIDTH_DATA, default 24, pixel width (RGB888).
REQ-002 SHALL have parameter BOX_COLOR, default 24'hFF0000, border colour.
REQ-003 SHALL have parameter BOX_THICK, default 2, border thickness in pixels (1..7).
REQ-004 SHALL have parameter CAPTURE_FRAME, default 3, the upstream i_frame_cnt value at which box results are stable.
REQ-005 SHALL have port pixelclk, input, 1, the only clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_rgb, input, IMG_WIDTH_DATA, video pixel.
REQ-008 SHALL have ports i_hs / i_vs / i_de, input, 1 each, video syncs and data enable.
REQ-009 SHALL have ports i_hcount / i_vcount, input, 12 each, current pixel coordinates.
REQ-010 SHALL have port i_frame_cnt, input, 3, upstream projection frame phase (0..4).
REQ-011 SHALL have port i_box_l, input, 96, eight 12-bit left columns; box k in bits [12k+11:12k].
REQ-012 SHALL have port i_box_r, input, 96, eight 12-bit right columns, same packing.
REQ-013 SHALL have ports i_row_t / i_row_b, input, 12 each, common top/bottom row of the character line.
REQ-014 SHALL have port o_rgb, output, IMG_WIDTH_DATA, overlaid pixel.
REQ-015 SHALL have ports o_hs / o_vs / o_de, output, 1 each, syncs delayed to match o_rgb.
REQ-016 SHALL have port o_box_cnt, output, 4, number of valid boxes in the displayed set (0..8).

Function
REQ-017 SHALL detect vs falling edge as i_vs registered high and i_vs low.
REQ-018 SHALL copy i_box_l, i_box_r, i_row_t and i_row_b into shadow registers on a vs falling edge when i_frame_cnt == CAPTURE_FRAME; otherwise the shadows hold.
REQ-019 SHALL mark box k valid iff r_k > l_k and row_b > row_t, evaluated on the shadow values.
REQ-020 SHALL update o_box_cnt with the popcount of valid flags one cycle after a shadow update.
REQ-021 SHALL run FSM WAIT_FIRST -> ACTIVE on the first capture that yields o_box_cnt != 0; ACTIVE -> WAIT_FIRST on a capture with zero valid boxes; no other transitions.
REQ-022 SHALL pass i_rgb through unmodified in WAIT_FIRST.
REQ-023 SHALL, in ACTIVE, count pixel (h,v) as a border hit of valid box k iff row_t <= v <= row_b, l_k <= h <= r_k, and (h-l_k < BOX_THICK or r_k-h < BOX_THICK or v-row_t < BOX_THICK or row_b-v < BOX_THICK).
REQ-024 SHALL OR the hits of all eight boxes: overlapping or touching boxes produce a single BOX_COLOR pixel.
REQ-025 SHALL colour the whole interior when a box is narrower than 2*BOX_THICK.
REQ-026 SHALL have a fixed 2-cycle latency: stage 1 registers the hit and interior bits plus the pixel; stage 2 registers the output mux. o_hs/o_vs/o_de are delayed by exactly 2 cycles.
REQ-027 SHALL force o_rgb to 0 whenever the delayed de is low.
REQ-028 SHALL perform all comparisons unsigned at 12 bits; boxes wholly outside the frame never hit and cause no wrap.

Reset
REQ-029 SHALL, on reset, drive o_rgb=0, o_hs=0, o_vs=0, o_de=0, o_box_cnt=0, clear all shadows and pipeline registers, and set the FSM to WAIT_FIRST.
REQ-030 SHALL give reset priority over a simultaneous capture; reset asserted mid-frame drops the capture and the output is 0 until pipeline refill.

Configuration
REQ-031 SHALL, with CHAR_BOX_FILL_EN defined, replace each interior non-border pixel of a valid box by a per 8-bit channel value (pix>>1)+(BOX_COLOR>>1).
REQ-032 SHALL, without CHAR_BOX_FILL_EN, pass interior pixels through unchanged; latency is identical in both builds.

Structure
REQ-033 SHALL take NUM_BOX=8, COORD_W=12, the box typedef (l, r) and the FSM state enum from shared package char_box_pkg.
REQ-034 SHALL instantiate sub-module char_box_hit once per box: combinational border and interior test of one box against (h,v), with its outputs registered in stage 1 of the parent.

Verification
REQ-035 SHALL cover: box0 l=10 r=20, rows 5..15, i_frame_cnt=3 with vs falls -> next frame pixels (10,8) and (11,8) = FF0000, (12,8) = input, (20,15) = FF0000, o_box_cnt=1.
REQ-036 SHALL cover: a capture at i_frame_cnt=2 with changed boxes -> shadows and output unchanged.
REQ-037 SHALL cover: all boxes l=r=0 captured while ACTIVE -> o_box_cnt=0, FSM in WAIT_FIRST, output equals input delayed 2 cycles.
REQ-038 SHALL cover: box1 l=20 r=22 (narrower than 2*BOX_THICK) overlapping box0 -> columns 20..22 fully coloured, no glitch at the overlap.
REQ-039 SHALL cover: reset pulsed mid-line while ACTIVE -> next cycle all outputs 0, o_box_cnt=0, pass-through after 2 cycles.
REQ-040 SHALL cover: CHAR_BOX_FILL_EN build with pixel 0x202020 inside box0 -> o_rgb=0x8F1010.
